psg_write_sequencer: RTL and testbench
======================================

# psg_write_sequencer

Command-level front end for the SN76489 PSG core. It accepts high-level register updates (tone period, attenuation, noise control, timed waits) from a valid/ready requester and buffers them in a small FIFO. It expands each update into the PSG's latch/data byte protocol and drives the core's single-cycle byte-write port, enforcing a minimum spacing between writes. It sits between a player or host interface and the PSG write inputs (`we`, `data`).

## Interface
Parameters:
- `FIFO_DEPTH`, 4: command FIFO entries (power of 2, ≥2).
- `WRITE_GAP`, 16: cycles from one `psg_we` pulse to the next (≥2).
- `WAIT_BITS`, 16: width of the wait counter.

Ports:
- `clk`  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept the command; equals !full.
- `cmd_op`  in  2  operation: 00 tone, 01 attenuation, 10 noise, 11 wait.
- `cmd_chan`  in  2  channel 0..3.
- `cmd_value`  in  WAIT_BITS  payload: tone uses [9:0], attenuation uses [3:0], noise uses [2:0], wait uses all bits.
- `tick`  in  1  wait timebase strobe, one cycle wide.
- `psg_we`  out  1  one-cycle active-high write strobe to the PSG.
- `psg_data`  out  8  byte presented with `psg_we`; holds its last value otherwise.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- Push: when `cmd_valid & cmd_ready` at an edge, {op, chan, value} is written to the FIFO.
  - No push when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle are both performed when the FIFO is neither full nor empty.
  - No fall-through: an entry pushed into an empty FIFO is popped no earlier than the next edge.
- FSM states: IDLE, GAP, WAIT.
  - IDLE: if the FIFO is non-empty, pop and execute the head command.
  - Executing a command that emits bytes: register `psg_we`=1 and `psg_data`=byte1, load gap_cnt=WRITE_GAP-1, go to GAP. For a tone command, set pend2 and save byte2.
  - GAP: decrement gap_cnt each cycle. When gap_cnt==0:
    - if pend2: emit byte2, clear pend2, reload gap_cnt, stay in GAP;
    - else if the FIFO is non-empty: pop and execute on this same edge;
    - else go to IDLE.
  - WAIT: decrement wait_cnt on each `tick`. When wait_cnt reaches 0, behave as the GAP-end case without pend2. A `tick` in the same cycle as the pop is ignored.
- Byte encoding:
  - Tone (chan 0..2): byte1={1,chan,0,value[3:0]}; byte2={00,value[9:4]}.
  - Tone with chan 3: popped and discarded. No write. FSM stays or returns to IDLE.
  - Attenuation: single byte {1,chan,1,value[3:0]}.
  - Noise: single byte {1,110,0,value[2:0]}; chan is ignored.
  - Wait: no write. value==0 completes immediately, the same as a discarded command. Otherwise load wait_cnt=value and enter WAIT.
- Write order always equals command order. A tone's two bytes are never separated by another command's byte.

## Timing
- Reset values: `psg_we`=0, `psg_data`=0x00, `cmd_ready`=1, `busy`=0. FIFO empty, FSM IDLE, pend2=0, all counters 0.
- Reset mid-operation: on the next cycle all state is cleared, including any pending byte2 and queued commands. `psg_we` stays 0.
- Latency: a command accepted at edge E0 into an empty FIFO with the FSM in IDLE produces `psg_we` high in the cycle following edge E0+1.
- Spacing: consecutive `psg_we` pulses are exactly WRITE_GAP cycles apart, rising to rising, both within a tone command and between back-to-back commands.
- Spacing after a wait: the first write after a wait occurs on the edge after the final `tick`.
- `psg_we` is never high in two consecutive cycles.
- `busy` falls in the same cycle the FSM enters IDLE with the FIFO empty.
- `cmd_ready` is registered-state derived, with no combinational path from `cmd_valid`.

## Test plan
- Tone, chan 1, value 0x2AB, WRITE_GAP=16 -> `psg_we` pulse with `psg_data`=0xAB, then exactly 16 cycles later a pulse with 0x2A. `busy` is 0 after 16 more cycles.
- Attenuation chan 3 value 0xF, then noise value 5, pushed back-to-back -> pulses with 0xFF then 0xE5, 16 cycles apart.
- Attenuation chan 0 value 2, wait value 3, attenuation chan 0 value 9 -> 0x92 is written, then no write until the edge after the third `tick`, then 0x99.
- Wait value 1000, then push 5 commands -> `cmd_ready` drops after 4 accepted. The 5th is held until a pop. All bytes appear in push order.
- Tone chan 3, then attenuation chan 2 value 0 -> only 0xD0 is written. No stray `psg_we`.
- Reset asserted 5 cycles after a tone's byte1 -> byte2 is never emitted. `psg_we`=0, `busy`=0 and `cmd_ready`=1 from the first cycle after reset.

Source files
------------

// File: rtl/psg_write_sequencer_if.sv
// Command handshake between a requester (master) and psg_write_sequencer (slave).
interface psg_write_sequencer_if #(
    parameter int WAIT_BITS = 16
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [1:0]           cmd_chan;
    logic [WAIT_BITS-1:0] cmd_value;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_chan,
        output cmd_value,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_chan,
        input  cmd_value,
        output cmd_ready
    );
endinterface

// File: rtl/psg_write_sequencer.sv
// SN76489 write sequencer: buffers high-level register updates in a small FIFO
// and expands them into spaced latch/data byte writes on the PSG write port.
module psg_write_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WRITE_GAP  = 16,
    parameter int WAIT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    psg_write_sequencer_if.slave cmd,
    input  logic                 tick,
    output logic                 psg_we,
    output logic [7:0]           psg_data,
    output logic                 busy
);
    localparam int ADDR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENTRY_W = 4 + WAIT_BITS;
    localparam int GAP_W   = $clog2(WRITE_GAP);

    localparam logic [ADDR_W:0]  DEPTH_FULL = (ADDR_W+1)'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(WRITE_GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_WAIT} state_t;
    typedef enum logic [1:0] {OP_TONE, OP_ATTEN, OP_NOISE, OP_WAIT} op_t;

    state_t               state_q, state_d;
    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   mem_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [WAIT_BITS-1:0] wait_cnt_q, wait_cnt_d;
    logic                 pend2_q, pend2_d;
    logic [7:0]           byte2_q, byte2_d;
    logic                 psg_we_q, psg_we_d;
    logic [7:0]           psg_data_q, psg_data_d;

    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 exec;
    logic [ENTRY_W-1:0]   head;
    op_t                  head_op;
    logic [1:0]           head_chan;
    logic [WAIT_BITS-1:0] head_value;

    // FIFO status and head-of-queue decode, all from registered state
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_FULL);
        push       = cmd.cmd_valid && !fifo_full;
        head       = mem_q[rd_ptr_q];
        head_op    = op_t'(head[ENTRY_W-1 -: 2]);
        head_chan  = head[ENTRY_W-3 -: 2];
        head_value = head[WAIT_BITS-1:0];
    end

    // State register: every flop, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            gap_cnt_q  <= '0;
            wait_cnt_q <= '0;
            pend2_q    <= 1'b0;
            byte2_q    <= '0;
            psg_we_q   <= 1'b0;
            psg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            gap_cnt_q  <= gap_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            pend2_q    <= pend2_d;
            byte2_q    <= byte2_d;
            psg_we_q   <= psg_we_d;
            psg_data_q <= psg_data_d;
        end
    end

    // Next state: gap/wait timing, then decode of the popped head command
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        wait_cnt_d = wait_cnt_q;
        pend2_d    = pend2_q;
        byte2_d    = byte2_q;
        psg_we_d   = 1'b0;
        psg_data_d = psg_data_q;
        exec       = 1'b0;

        unique case (state_q)
            S_IDLE: exec = !fifo_empty;
            S_GAP: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else if (pend2_q) begin
                    psg_we_d   = 1'b1;
                    psg_data_d = byte2_q;
                    pend2_d    = 1'b0;
                    gap_cnt_d  = GAP_LOAD;
                end else if (!fifo_empty) begin
                    exec = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // The tick that takes the count to zero also ends the wait on
                // the same edge, so the next write lands on the edge after it.
                if (tick) begin
                    if (wait_cnt_q <= WAIT_BITS'(1)) begin
                        wait_cnt_d = '0;
                        if (!fifo_empty) begin
                            exec = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q - WAIT_BITS'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (exec) begin
            // Discarded tones and zero waits complete immediately via IDLE.
            state_d = S_IDLE;
            unique case (head_op)
                OP_TONE: begin
                    if (head_chan != 2'd3) begin
                        psg_we_d   = 1'b1;
                        psg_data_d = {1'b1, head_chan, 1'b0, head_value[3:0]};
                        byte2_d    = {2'b00, head_value[9:4]};
                        pend2_d    = 1'b1;
                        gap_cnt_d  = GAP_LOAD;
                        state_d    = S_GAP;
                    end
                end
                OP_ATTEN: begin
                    psg_we_d   = 1'b1;
                    psg_data_d = {1'b1, head_chan, 1'b1, head_value[3:0]};
                    gap_cnt_d  = GAP_LOAD;
                    state_d    = S_GAP;
                end
                OP_NOISE: begin
                    psg_we_d   = 1'b1;
                    psg_data_d = {1'b1, 3'b110, 1'b0, head_value[2:0]};
                    gap_cnt_d  = GAP_LOAD;
                    state_d    = S_GAP;
                end
                OP_WAIT: begin
                    if (head_value != '0) begin
                        wait_cnt_d = head_value;
                        state_d    = S_WAIT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FIFO storage and pointers: push from requester, pop when a command executes
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {cmd.cmd_op, cmd.cmd_chan, cmd.cmd_value};
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end
        if (exec) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        unique case ({push, exec})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Outputs: all derived from registered state
    always_comb begin
        cmd.cmd_ready = !fifo_full;
        psg_we        = psg_we_q;
        psg_data      = psg_data_q;
        busy          = !fifo_empty || (state_q != S_IDLE);
    end
endmodule

// File: tb/tb_psg_write_sequencer.sv
// Self-checking bench for psg_write_sequencer: directed scenarios plus a
// randomized run compared against an event-level timing model.
module tb_psg_write_sequencer;
    localparam int FIFO_DEPTH = 4;
    localparam int WRITE_GAP  = 16;
    localparam int WAIT_BITS  = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic       psg_we;
    logic [7:0] psg_data;
    logic       busy;

    psg_write_sequencer_if #(.WAIT_BITS(WAIT_BITS)) cmd_if ();

    psg_write_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .WRITE_GAP (WRITE_GAP),
        .WAIT_BITS (WAIT_BITS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cmd     (cmd_if),
        .tick    (tick),
        .psg_we  (psg_we),
        .psg_data(psg_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge it equals the number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick generator: 0 off, 1 random (~25%), 2 every cycle
    int tick_mode = 0;
    always @(posedge clk) begin
        #1;
        case (tick_mode)
            0:       tick = 1'b0;
            1:       tick = ($urandom_range(0, 3) == 0);
            default: tick = 1'b1;
        endcase
    end

    typedef struct { int e; logic [7:0] d; } wr_t;
    typedef struct { int e; logic [1:0] op; logic [1:0] chan; logic [15:0] value; } acc_t;

    wr_t  wr_q[$];
    acc_t acc_q[$];
    int   tick_q[$];
    logic prev_we = 1'b0;
    int   we_violations = 0;

    int n_checks = 0;
    int n_pass   = 0;

    // Observer: writes (edge that raised psg_we), accepted commands and ticks
    // (edge that samples them).
    always @(negedge clk) begin
        if (psg_we === 1'b1) begin
            wr_q.push_back('{e: cyc, d: psg_data});
            if (prev_we === 1'b1) we_violations++;
        end
        if (reset === 1'b0) begin
            if (cmd_if.cmd_valid && cmd_if.cmd_ready)
                acc_q.push_back('{e: cyc + 1, op: cmd_if.cmd_op, chan: cmd_if.cmd_chan,
                                  value: cmd_if.cmd_value});
            if (tick) tick_q.push_back(cyc + 1);
        end
        prev_we = psg_we;
    end

    task automatic send(input logic [1:0] op, input logic [1:0] chan, input logic [15:0] value);
        int   n;
        logic acc;
        n = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_chan  = chan;
        cmd_if.cmd_value = value;
        forever begin
            @(negedge clk);
            acc = cmd_if.cmd_ready && !reset;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 3000) begin
                n_checks++;
                $display("FAIL send_timeout: command op=%0d not accepted after %0d cycles, required acceptance", op, n);
                break;
            end
        end
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int idle_edge, output bit ok);
        ok = 1'b0;
        idle_edge = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                idle_edge = cyc;
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        n_checks++; if (psg_we !== 1'b0) $display("FAIL reset_we: got %b expected 0", psg_we); else n_pass++;
        n_checks++; if (psg_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", psg_data); else n_pass++;
        n_checks++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cmd_if.cmd_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_tone();
        int wb, ab, ie;
        bit ok;
        wb = wr_q.size();
        ab = acc_q.size();
        send(2'd0, 2'd1, 16'h02AB);
        wait_idle(ie, ok);
        n_checks++; if (!ok) $display("FAIL tone_idle: busy never fell, required idle"); else n_pass++;
        n_checks++; if (wr_q.size() - wb != 2) $display("FAIL tone_count: got %0d writes expected 2", wr_q.size() - wb); else n_pass++;
        if (wr_q.size() - wb == 2 && acc_q.size() > ab) begin
            n_checks++; if (wr_q[wb].d !== 8'hAB) $display("FAIL tone_byte1: got %h expected AB", wr_q[wb].d); else n_pass++;
            n_checks++; if (wr_q[wb].e != acc_q[ab].e + 1) $display("FAIL tone_latency: write edge %0d expected %0d", wr_q[wb].e, acc_q[ab].e + 1); else n_pass++;
            n_checks++; if (wr_q[wb+1].d !== 8'h2A) $display("FAIL tone_byte2: got %h expected 2A", wr_q[wb+1].d); else n_pass++;
            n_checks++; if (wr_q[wb+1].e - wr_q[wb].e != WRITE_GAP) $display("FAIL tone_spacing: got %0d expected %0d", wr_q[wb+1].e - wr_q[wb].e, WRITE_GAP); else n_pass++;
            n_checks++; if (ie != wr_q[wb+1].e + WRITE_GAP) $display("FAIL tone_busy_fall: got edge %0d expected %0d", ie, wr_q[wb+1].e + WRITE_GAP); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int wb, ie;
        bit ok;
        logic [15:0] nv;
        wb = wr_q.size();
        nv = 16'(($urandom_range(0, 8191) << 3) | 5);
        send(2'd1, 2'd3, 16'h000F);
        send(2'd2, 2'($urandom_range(0, 3)), nv);
        wait_idle(ie, ok);
        n_checks++; if (!ok) $display("FAIL b2b_idle: busy never fell, required idle"); else n_pass++;
        n_checks++; if (wr_q.size() - wb != 2) $display("FAIL b2b_count: got %0d writes expected 2", wr_q.size() - wb); else n_pass++;
        if (wr_q.size() - wb == 2) begin
            n_checks++; if (wr_q[wb].d !== 8'hFF) $display("FAIL b2b_atten: got %h expected FF", wr_q[wb].d); else n_pass++;
            n_checks++; if (wr_q[wb+1].d !== 8'hE5) $display("FAIL b2b_noise: got %h expected E5", wr_q[wb+1].d); else n_pass++;
            n_checks++; if (wr_q[wb+1].e - wr_q[wb].e != WRITE_GAP) $display("FAIL b2b_spacing: got %0d expected %0d", wr_q[wb+1].e - wr_q[wb].e, WRITE_GAP); else n_pass++;
        end
    endtask

    task automatic test_wait();
        int wb, ie, n, exp_e;
        bit ok;
        wb = wr_q.size();
        tick_mode = 1;
        send(2'd1, 2'd0, 16'd2);
        send(2'd3, 2'd0, 16'd3);
        send(2'd1, 2'd0, 16'd9);
        wait_idle(ie, ok);
        tick_mode = 0;
        n_checks++; if (!ok) $display("FAIL wait_idle: busy never fell, required idle"); else n_pass++;
        n_checks++; if (wr_q.size() - wb != 2) $display("FAIL wait_count: got %0d writes expected 2", wr_q.size() - wb); else n_pass++;
        if (wr_q.size() - wb == 2) begin
            // Wait pops at the end of the first write's gap; third later tick ends it.
            n = 0;
            exp_e = -1;
            foreach (tick_q[i]) begin
                if (tick_q[i] > wr_q[wb].e + WRITE_GAP) begin
                    n++;
                    if (n == 3) begin exp_e = tick_q[i]; break; end
                end
            end
            n_checks++; if (wr_q[wb].d !== 8'h92) $display("FAIL wait_first: got %h expected 92", wr_q[wb].d); else n_pass++;
            n_checks++; if (wr_q[wb+1].d !== 8'h99) $display("FAIL wait_second: got %h expected 99", wr_q[wb+1].d); else n_pass++;
            n_checks++; if (wr_q[wb+1].e != exp_e) $display("FAIL wait_timing: write edge %0d expected %0d", wr_q[wb+1].e, exp_e); else n_pass++;
        end
    endtask

    task automatic test_full();
        int wb, ab, ie, held;
        bit ok;
        logic [1:0]  ch  [4];
        logic [3:0]  va  [4];
        logic [7:0]  exp_d [5];
        logic [15:0] nv;
        wb = wr_q.size();
        ab = acc_q.size();
        tick_mode = 0;
        send(2'd3, 2'd0, 16'd1000);
        for (int k = 0; k < 4; k++) begin
            ch[k] = 2'($urandom_range(0, 3));
            va[k] = 4'($urandom_range(0, 15));
            exp_d[k] = 8'(144 + 32 * int'(ch[k]) + int'(va[k]));
            send(2'd1, ch[k], {12'h000, va[k]});
        end
        nv = 16'($urandom_range(0, 65535));
        exp_d[4] = 8'(224 + int'(nv) % 8);
        @(negedge clk);
        n_checks++; if (cmd_if.cmd_ready !== 1'b0) $display("FAIL full_ready: got %b expected 0", cmd_if.cmd_ready); else n_pass++;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'd2;
        cmd_if.cmd_chan  = 2'd1;
        cmd_if.cmd_value = nv;
        held = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_if.cmd_ready) held++;
            @(posedge clk); #1;
        end
        n_checks++; if (held != 0) $display("FAIL full_hold: ready high %0d cycles expected 0", held); else n_pass++;
        n_checks++; if (acc_q.size() - ab != 5) $display("FAIL full_accepted: got %0d expected 5", acc_q.size() - ab); else n_pass++;
        tick_mode = 2;
        send(2'd2, 2'd1, nv);
        wait_idle(ie, ok);
        tick_mode = 0;
        n_checks++; if (!ok) $display("FAIL full_idle: busy never fell, required idle"); else n_pass++;
        n_checks++; if (wr_q.size() - wb != 5) $display("FAIL full_count: got %0d writes expected 5", wr_q.size() - wb); else n_pass++;
        if (wr_q.size() - wb == 5) begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (wr_q[wb+k].d !== exp_d[k]) $display("FAIL full_order[%0d]: got %h expected %h", k, wr_q[wb+k].d, exp_d[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_discard();
        int wb, ie;
        bit ok;
        wb = wr_q.size();
        send(2'd0, 2'd3, 16'($urandom_range(0, 1023)));
        send(2'd1, 2'd2, 16'd0);
        wait_idle(ie, ok);
        n_checks++; if (!ok) $display("FAIL discard_idle: busy never fell, required idle"); else n_pass++;
        n_checks++; if (wr_q.size() - wb != 1) $display("FAIL discard_count: got %0d writes expected 1", wr_q.size() - wb); else n_pass++;
        if (wr_q.size() - wb == 1) begin
            n_checks++; if (wr_q[wb].d !== 8'hD0) $display("FAIL discard_data: got %h expected D0", wr_q[wb].d); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int  wb;
        bit  got;
        wb = wr_q.size();
        send(2'd0, 2'd1, 16'h0155);
        send(2'd1, 2'd2, 16'h0007);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_q.size() > wb) begin got = 1'b1; break; end
        end
        n_checks++; if (!got) $display("FAIL rstmid_byte1: no write seen, required one"); else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (psg_we !== 1'b0) $display("FAIL rstmid_we: got %b expected 0", psg_we); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (cmd_if.cmd_ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", cmd_if.cmd_ready); else n_pass++;
        n_checks++; if (psg_data !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", psg_data); else n_pass++;
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if (wr_q.size() - wb != 1) $display("FAIL rstmid_count: got %0d writes expected 1", wr_q.size() - wb); else n_pass++;
    endtask

    task automatic test_random();
        int  wb, ab, ie, ready, p, n, t, idle;
        bit  ok;
        wr_t exp_q[$];
        logic [1:0]  op, ch;
        logic [15:0] v;
        wb = wr_q.size();
        ab = acc_q.size();
        tick_mode = 1;
        for (int k = 0; k < 30; k++) begin
            op = 2'($urandom_range(0, 3));
            ch = 2'($urandom_range(0, 3));
            v  = (op == 2'd3) ? 16'($urandom_range(0, 5)) : 16'($urandom);
            send(op, ch, v);
            idle = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 30));
            repeat (idle) begin @(posedge clk); #1; end
        end
        wait_idle(ie, ok);
        tick_mode = 0;
        n_checks++; if (!ok) $display("FAIL rand_idle: busy never fell, required idle"); else n_pass++;

        // Each command starts at the later of "sequencer free" and the edge
        // after its acceptance; writes then follow at fixed multiples of the gap.
        ready = 0;
        for (int k = ab; k < acc_q.size(); k++) begin
            p = (ready > acc_q[k].e + 1) ? ready : acc_q[k].e + 1;
            case (acc_q[k].op)
                2'd0: begin
                    if (acc_q[k].chan == 2'd3) begin
                        ready = p + 1;
                    end else begin
                        exp_q.push_back('{e: p, d: 8'(128 + 32 * int'(acc_q[k].chan) + int'(acc_q[k].value) % 16)});
                        exp_q.push_back('{e: p + WRITE_GAP, d: 8'((int'(acc_q[k].value) / 16) % 64)});
                        ready = p + 2 * WRITE_GAP;
                    end
                end
                2'd1: begin
                    exp_q.push_back('{e: p, d: 8'(144 + 32 * int'(acc_q[k].chan) + int'(acc_q[k].value) % 16)});
                    ready = p + WRITE_GAP;
                end
                2'd2: begin
                    exp_q.push_back('{e: p, d: 8'(224 + int'(acc_q[k].value) % 8)});
                    ready = p + WRITE_GAP;
                end
                default: begin
                    if (acc_q[k].value == 16'd0) begin
                        ready = p + 1;
                    end else begin
                        n = 0;
                        t = p + 100000;
                        foreach (tick_q[i]) begin
                            if (tick_q[i] > p) begin
                                n++;
                                if (n == int'(acc_q[k].value)) begin t = tick_q[i]; break; end
                            end
                        end
                        ready = t;
                    end
                end
            endcase
        end

        n_checks++; if (wr_q.size() - wb != exp_q.size()) $display("FAIL rand_count: got %0d writes expected %0d", wr_q.size() - wb, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && wb + i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[wb+i].d !== exp_q[i].d) $display("FAIL rand_data[%0d]: got %h expected %h", i, wr_q[wb+i].d, exp_q[i].d);
            else n_pass++;
            n_checks++;
            if (wr_q[wb+i].e != exp_q[i].e) $display("FAIL rand_edge[%0d]: got %0d expected %0d", i, wr_q[wb+i].e, exp_q[i].e);
            else n_pass++;
        end
    endtask

    task automatic test_no_consecutive();
        n_checks++;
        if (we_violations != 0) $display("FAIL we_isolated: got %0d back-to-back strobes expected 0", we_violations);
        else n_pass++;
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'd0;
        cmd_if.cmd_chan  = 2'd0;
        cmd_if.cmd_value = '0;
        @(posedge clk); #1;
        test_reset();
        test_tone();
        test_back_to_back();
        test_wait();
        test_full();
        test_discard();
        test_reset_mid();
        test_random();
        test_no_consecutive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
